// File: rtl/ppu_clock_sequencer.sv
// PPU power-up clock sequencer: holds both PPUs in reset for R full XIN
// periods, releases them, then keeps toggling XIN until stopped.
// All strobes are single-cycle pulses decoded from registered state.
module ppu_clock_sequencer #(
  parameter int HALF_W  = 8,
  parameter int COUNT_W = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start_i,
  input  logic               stop_i,
  input  logic [HALF_W-1:0]  half_period_i,
  input  logic [COUNT_W-1:0] reset_cycles_i,
  output logic               xin_hi_o,
  output logic               xin_lo_o,
  output logic               set_ppu_reset_o,
  output logic               clr_ppu_reset_o,
  output logic               busy_o,
  output logic               ppu_held_o,
  output logic [COUNT_W-1:0] xin_edges_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ASSERT,
    S_HOLD,
    S_RELEASE,
    S_RUN,
    S_STOP
  } state_t;

  state_t             state_q, state_d;
  logic [HALF_W-1:0]  half_q;
  logic [HALF_W-1:0]  timer_q;
  logic [COUNT_W-1:0] rcyc_q;
  logic [COUNT_W-1:0] periods_q;
  logic [COUNT_W-1:0] edges_q;
  logic               phase_q;
  logic               accept;
  logic               timing;
  logic               tick;
  logic               hold_done;

  assign accept    = (state_q == S_IDLE) && start_i && !stop_i;
  assign timing    = (state_q == S_HOLD) || (state_q == S_RELEASE) || (state_q == S_RUN);
  assign tick      = timing && (timer_q == HALF_W'(1));
  // The R-th full period ends on the falling toggle after R-1 earlier ones.
  assign hold_done = (state_q == S_HOLD) && tick && phase_q &&
                     (periods_q == rcyc_q - COUNT_W'(1));
  assign xin_edges_o = edges_q;

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state decode; stop lets the current cycle finish, then goes to STOP
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (accept) state_d = S_ASSERT;
      S_ASSERT:  if (stop_i) state_d = S_STOP;
                 else if (rcyc_q != '0) state_d = S_HOLD;
                 else state_d = S_RELEASE;
      S_HOLD:    if (stop_i) state_d = S_STOP;
                 else if (hold_done) state_d = S_RELEASE;
      S_RELEASE: if (stop_i) state_d = S_STOP;
                 else state_d = S_RUN;
      S_RUN:     if (stop_i) state_d = S_STOP;
      S_STOP:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Output strobes and status decoded from state, timer and phase
  always_comb begin
    xin_hi_o        = tick && !phase_q;
    xin_lo_o        = (tick && phase_q) || (state_q == S_ASSERT) || (state_q == S_STOP);
    set_ppu_reset_o = (state_q == S_ASSERT) || (state_q == S_STOP);
    clr_ppu_reset_o = (state_q == S_RELEASE);
    busy_o          = (state_q != S_IDLE);
    ppu_held_o      = (state_q == S_ASSERT) || (state_q == S_HOLD);
  end

  // Settings latch, half-period timer, XIN phase and counters
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      half_q    <= '0;
      timer_q   <= '0;
      rcyc_q    <= '0;
      periods_q <= '0;
      edges_q   <= '0;
      phase_q   <= 1'b0;
    end else begin
      if (accept) begin
        half_q    <= (half_period_i == '0) ? HALF_W'(1) : half_period_i;
        rcyc_q    <= reset_cycles_i;
        periods_q <= '0;
        edges_q   <= '0;
        phase_q   <= 1'b0;
      end
      if (state_q == S_ASSERT) timer_q <= half_q;
      if (timing) begin
        if (tick) begin
          timer_q <= half_q;
          phase_q <= ~phase_q;
          if (!phase_q) edges_q <= edges_q + COUNT_W'(1);
          if (phase_q && (state_q == S_HOLD)) periods_q <= periods_q + COUNT_W'(1);
        end else begin
          timer_q <= timer_q - HALF_W'(1);
        end
      end
      if (state_q == S_STOP) phase_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ppu_clock_sequencer.sv
// Bench for ppu_clock_sequencer: a cycle-offset model predicts every output
// of two instances (COUNT_W=16 and COUNT_W=4) each cycle; directed
// checks pin specific cycles of each scenario with literal values.
module tb_ppu_clock_sequencer;

  logic        clock;
  logic        reset;
  logic        start_i;
  logic        stop_i;
  logic [7:0]  half_period_i;
  logic [15:0] reset_cycles_i;

  logic        hi, lo, setr, clrr, busy, held;
  logic [15:0] edges;
  logic        hi4, lo4, setr4, clrr4, busy4, held4;
  logic [3:0]  edges4;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  ppu_clock_sequencer #(.HALF_W(8), .COUNT_W(16)) dut (
    .clock(clock), .reset(reset), .start_i(start_i), .stop_i(stop_i),
    .half_period_i(half_period_i), .reset_cycles_i(reset_cycles_i),
    .xin_hi_o(hi), .xin_lo_o(lo), .set_ppu_reset_o(setr), .clr_ppu_reset_o(clrr),
    .busy_o(busy), .ppu_held_o(held), .xin_edges_o(edges)
  );

  ppu_clock_sequencer #(.HALF_W(8), .COUNT_W(4)) dut4 (
    .clock(clock), .reset(reset), .start_i(start_i), .stop_i(stop_i),
    .half_period_i(half_period_i), .reset_cycles_i(reset_cycles_i[3:0]),
    .xin_hi_o(hi4), .xin_lo_o(lo4), .set_ppu_reset_o(setr4), .clr_ppu_reset_o(clrr4),
    .busy_o(busy4), .ppu_held_o(held4), .xin_edges_o(edges4)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic go(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Model: a sequence accepted in cycle T is described by offset k = cyc - T.
  // k=1 is the assert cycle; XIN toggles at k = 1 + H*j (j odd: high, j even:
  // low); release at k = 2 (R=0) or 2 + 2*H*R; stop_i in cycle S makes S+1 the
  // stop cycle and ends the sequence.
  int m_active = 0;
  int m_t0     = 0;
  int m_h      = 1;
  int m_r      = 0;
  int m_stop   = -1;
  int m_edges  = 0;
  int k, krel, j;
  logic e_hi, e_lo, e_set, e_clr, e_busy, e_held;

  initial forever begin
    @(negedge clock);
    e_hi = 0; e_lo = 0; e_set = 0; e_clr = 0; e_busy = 0; e_held = 0;
    if (reset) begin
      m_active = 0;
      m_edges  = 0;
    end else if (m_active != 0) begin
      k = cyc - m_t0;
      e_busy = 1;
      if (m_stop >= 0 && cyc == m_stop + 1) begin
        e_lo = 1; e_set = 1;
      end else if (k == 1) begin
        e_lo = 1; e_set = 1; e_held = 1;
      end else begin
        krel   = (m_r == 0) ? 2 : 2 + 2 * m_h * m_r;
        e_held = (k < krel);
        e_clr  = (k == krel);
        if ((k - 1) % m_h == 0) begin
          j = (k - 1) / m_h;
          if (j % 2 == 1) e_hi = 1;
          else            e_lo = 1;
        end
      end
    end
    chk("xin_hi",   32'(hi),    32'(e_hi));
    chk("xin_lo",   32'(lo),    32'(e_lo));
    chk("set_rst",  32'(setr),  32'(e_set));
    chk("clr_rst",  32'(clrr),  32'(e_clr));
    chk("busy",     32'(busy),  32'(e_busy));
    chk("held",     32'(held),  32'(e_held));
    chk("edges",    32'(edges), 32'(m_edges % 65536));
    chk("xin_hi4",  32'(hi4),   32'(e_hi));
    chk("xin_lo4",  32'(lo4),   32'(e_lo));
    chk("set_rst4", 32'(setr4), 32'(e_set));
    chk("clr_rst4", 32'(clrr4), 32'(e_clr));
    chk("busy4",    32'(busy4), 32'(e_busy));
    chk("held4",    32'(held4), 32'(e_held));
    chk("edges4",   32'(edges4), 32'(m_edges % 16));
    if (!reset) begin
      if (m_active != 0) begin
        if (e_hi) m_edges++;
        if (m_stop >= 0 && cyc == m_stop + 1) m_active = 0;
        else if (stop_i && m_stop < 0) m_stop = cyc;
      end else if (start_i && !stop_i) begin
        m_active = 1;
        m_t0     = cyc;
        m_h      = (half_period_i == 8'd0) ? 1 : int'(half_period_i);
        m_r      = int'(reset_cycles_i);
        m_stop   = -1;
        m_edges  = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; start_i = 1'b0; stop_i = 1'b0;
    half_period_i = 8'd0; reset_cycles_i = 16'd0;
    #1 reset = 1'b1;
    #2;
    chk("rst_busy",  32'(busy),  32'd0);
    chk("rst_edges", 32'(edges), 32'd0);
    chk("rst_lo",    32'(lo),    32'd0);
    go(2);
    reset = 1'b0;

    // H=2, R=3 power-up, with an ignored start during HOLD
    go(1); start_i = 1; half_period_i = 8'd2; reset_cycles_i = 16'd3;
    go(1); start_i = 0; #1;
    chk("s1_assert_set", 32'(setr), 32'd1);
    chk("s1_assert_lo",  32'(lo),   32'd1);
    go(2); #1 chk("s1_hi_t3", 32'(hi), 32'd1);
    go(2); #1 chk("s1_lo_t5", 32'(lo), 32'd1);
    go(1); start_i = 1; half_period_i = 8'd5; reset_cycles_i = 16'd7;
    go(1); start_i = 0; #1 chk("s1_hi_t7", 32'(hi), 32'd1);
    go(6); #1;
    chk("s1_lo_t13",   32'(lo),   32'd1);
    chk("s1_held_t13", 32'(held), 32'd1);
    go(1); #1;
    chk("s1_clr_t14",   32'(clrr),  32'd1);
    chk("s1_held_t14",  32'(held),  32'd0);
    chk("s1_edges_t14", 32'(edges), 32'd3);
    go(4); stop_i = 1;
    go(1); stop_i = 0; #1;
    chk("s1_stop_lo",  32'(lo),   32'd1);
    chk("s1_stop_set", 32'(setr), 32'd1);
    chk("s1_stop_hi",  32'(hi),   32'd0);
    go(1); #1;
    chk("s1_busy_off", 32'(busy),  32'd0);
    chk("s1_edges",    32'(edges), 32'd4);

    // start and stop together in IDLE resolve as stop
    go(2); start_i = 1; stop_i = 1;
    go(1); start_i = 0; stop_i = 0; #1 chk("s3_busy", 32'(busy), 32'd0);
    go(1); #1 chk("s3_busy2", 32'(busy), 32'd0);

    // half_period 0 treated as 1, R=0, then stop in RUN
    go(1); start_i = 1; half_period_i = 8'd0; reset_cycles_i = 16'd0;
    go(1); start_i = 0; #1 chk("s2_set_t1", 32'(setr), 32'd1);
    go(1); #1;
    chk("s2_clr_t2", 32'(clrr), 32'd1);
    chk("s2_hi_t2",  32'(hi),   32'd1);
    go(1); #1 chk("s2_lo_t3", 32'(lo), 32'd1);
    go(7); stop_i = 1;
    go(1); stop_i = 0; #1;
    chk("s2_stop_lo",  32'(lo),   32'd1);
    chk("s2_stop_set", 32'(setr), 32'd1);
    chk("s2_stop_hi",  32'(hi),   32'd0);
    chk("s2_stop_clr", 32'(clrr), 32'd0);
    go(1); #1;
    chk("s2_busy_off", 32'(busy),  32'd0);
    chk("s2_edges",    32'(edges), 32'd5);
    go(4); #1 chk("s2_edges_frozen", 32'(edges), 32'd5);

    // 20 XIN periods wrap the 4-bit counter, then async reset mid-RUN
    go(1); start_i = 1; half_period_i = 8'd1; reset_cycles_i = 16'd0;
    go(1); start_i = 0;
    go(40); #1;
    chk("s4_edges16", 32'(edges),  32'd20);
    chk("s4_edges4",  32'(edges4), 32'd4);
    chk("s4_busy",    32'(busy),   32'd1);
    #1 reset = 1'b1;
    #1;
    chk("s4_rst_busy",   32'(busy),   32'd0);
    chk("s4_rst_lo",     32'(lo),     32'd0);
    chk("s4_rst_edges",  32'(edges),  32'd0);
    chk("s4_rst_edges4", 32'(edges4), 32'd0);
    chk("s4_rst_busy4",  32'(busy4),  32'd0);
    go(2); reset = 1'b0;

    // first start after reset, H=3, R=1
    go(1); start_i = 1; half_period_i = 8'd3; reset_cycles_i = 16'd1;
    go(1); start_i = 0;
    go(6); #1;
    chk("s5_lo_t7",   32'(lo),   32'd1);
    chk("s5_held_t7", 32'(held), 32'd1);
    go(1); #1;
    chk("s5_clr_t8",  32'(clrr), 32'd1);
    chk("s5_held_t8", 32'(held), 32'd0);
    go(3); stop_i = 1;
    go(1); stop_i = 0;
    go(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
